// File: rtl/crc32_check.sv
// crc32_check: byte-streaming CRC-32 frame checker.
//
// Takes a frame as message bytes followed by the 4-byte FCS, least
// significant FCS byte first. Each accepted byte is shifted through a
// reflected CRC-32 LFSR one bit per clock, LSB first. When the byte
// flagged with in_last has been shifted, the raw LFSR is compared against
// the CRC-32 residue and the result is reported with a one-cycle pulse.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   clear      synchronous abort / re-init, any state
//   in_valid   in_byte / in_last are valid
//   in_byte    frame byte, LSB processed first
//   in_last    marks the final byte (last FCS byte) of a frame
//   in_ready   a byte can be accepted this cycle
//   busy       shifting a byte or reporting a result
//   crc_out    running CRC (lfsr ^ XOR_OUT), meaningful while idle
//   chk_valid  one-cycle pulse, frame result available
//   chk_ok     frame matched the residue, valid from the cycle after the pulse
//   frame_len  byte count of the reported frame, saturating at all-ones

module crc32_check #(
    parameter logic [31:0] POLY    = 32'hEDB88320,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
    parameter int          CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    output logic             in_ready,
    output logic             busy,
    output logic [31:0]      crc_out,
    output logic             chk_valid,
    output logic             chk_ok,
    output logic [CNT_W-1:0] frame_len
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state;
    logic [31:0]      lfsr;
    logic [7:0]       sh;
    logic             last_flag;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] byte_cnt;

    // One step of the reflected LFSR for a single input bit.
    function automatic logic [31:0] crc_step(input logic [31:0] cur, input logic din);
        logic fb;
        fb = cur[0] ^ din;
        return (cur >> 1) ^ (fb ? POLY : 32'h0000_0000);
    endfunction

    // Status outputs are decoded straight from the state register; in_ready
    // also drops combinationally with clear so a byte is never taken
    // in the same cycle as an abort.
    assign in_ready  = (state == IDLE) && !clear;
    assign busy      = (state != IDLE);
    assign chk_valid = (state == REPORT);
    assign crc_out   = lfsr ^ XOR_OUT;

    // Frame FSM, LFSR datapath, byte counter and held report registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            lfsr      <= INIT;
            sh        <= 8'h00;
            last_flag <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= CNT_ZERO;
            chk_ok    <= 1'b0;
            frame_len <= CNT_ZERO;
        end else if (clear) begin
            // Abort: drop the partial frame, keep the last report visible.
            state    <= IDLE;
            lfsr     <= INIT;
            byte_cnt <= CNT_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sh        <= in_byte;
                        last_flag <= in_last;
                        bit_cnt   <= 3'd0;
                        if (byte_cnt != CNT_MAX) begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    lfsr    <= crc_step(lfsr, sh[0]);
                    sh      <= {1'b0, sh[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= last_flag ? REPORT : IDLE;
                    end
                end
                REPORT: begin
                    // Raw LFSR over message+FCS equals the fixed residue
                    // exactly when the FCS is correct.
                    chk_ok    <= (lfsr == RESIDUE);
                    frame_len <= byte_cnt;
                    lfsr      <= INIT;
                    byte_cnt  <= CNT_ZERO;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_check.sv
module tb_crc32_check;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          busy;
    logic [31:0]   crc_out;
    logic          chk_valid;
    logic          chk_ok;
    logic [CW-1:0] frame_len;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    crc32_check #(.CNT_W(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .busy      (busy),
        .crc_out   (crc_out),
        .chk_valid (chk_valid),
        .chk_ok    (chk_ok),
        .frame_len (frame_len)
    );

    typedef struct packed {
        logic          ok;
        logic          ok_care;
        logic [CW-1:0] len;
    } exp_t;

    typedef struct packed {
        logic [159:0]  data;
        logic [4:0]    n;
        logic          ok;
        logic          ok_care;
        logic [CW-1:0] len;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    vec_t good;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [159:0] d, input int n, input logic ok,
                                input logic care, input int len);
        vec_t v;
        v.data    = d;
        v.n       = n[4:0];
        v.ok      = ok;
        v.ok_care = care;
        v.len     = len[CW-1:0];
        return v;
    endfunction

    function automatic logic [7:0] vbyte(input vec_t v, input int i);
        int base;
        base = (int'(v.n) - 1 - i) * 8;
        return v.data[base +: 8];
    endfunction

    // Scoreboard: pop on each pulse, compare held results one cycle later.
    logic pend = 1'b0;
    exp_t cur;
    always @(negedge CLK) begin
        if (pend) begin
            pend = 1'b0;
            if (cur.ok_care) check("chk_ok", 32'(chk_ok), 32'(cur.ok));
            check("frame_len", 32'(frame_len), 32'(cur.len));
            check("crc_out_after_report", crc_out, 32'h0000_0000);
        end
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_chk_valid", 32'd1, 32'd0);
            end else begin
                cur  = exp_q.pop_front();
                pend = 1'b1;
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic l, input bit keep, output int waited);
        waited = 0;
        @(negedge CLK);
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = l;
        while (!in_ready && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int k;
        k = 0;
        while ((busy || pend || exp_q.size() != 0) && k < 40) begin
            @(negedge CLK);
            k++;
        end
        check("report_drained", 32'(exp_q.size()), 32'd0);
        @(negedge CLK);
    endtask

    task automatic send_vec(input vec_t v);
        int w;
        exp_q.push_back({v.ok, v.ok_care, v.len});
        for (int i = 0; i < int'(v.n); i++) begin
            send(vbyte(v, i), (i == int'(v.n) - 1), 1'b0, w);
        end
        wait_quiet();
    endtask

    initial begin
        int w;
        int k;
        int gap_bad;
        logic [71:0] msg;

        vecs[0] = mk(160'h3132333435363738392639F4CB, 13, 1'b1, 1'b1, 13);
        vecs[1] = mk(160'h3132333435363738392639F4CA, 13, 1'b0, 1'b1, 13);
        vecs[2] = mk(160'h3132333435363738392639F4CB, 13, 1'b1, 1'b1, 13);
        vecs[3] = mk(160'h00000000, 4, 1'b1, 1'b1, 4);
        vecs[4] = mk(160'h008DEF02D2, 5, 1'b1, 1'b1, 5);
        vecs[5] = mk(160'hFFFFFFFF, 4, 1'b0, 1'b1, 4);
        vecs[6] = mk(160'h31, 1, 1'b0, 1'b0, 1);
        vecs[7] = mk(160'h0, 17, 1'b0, 1'b0, 15);
        good = vecs[0];
        msg = 72'h313233343536373839;

        // Reset values while RST is held.
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_chk_valid", 32'(chk_valid), 32'd0);
        check("rst_crc_out", crc_out, 32'h0000_0000);
        check("rst_chk_ok", 32'(chk_ok), 32'd0);
        check("rst_frame_len", 32'(frame_len), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Plain CRC of "123456789" without in_last.
        for (int i = 0; i < 9; i++) begin
            send(msg[(8 - i) * 8 +: 8], 1'b0, 1'b0, w);
        end
        k = 0;
        while (busy && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("crc_123456789", crc_out, 32'hCBF4_3926);
        check("crc_idle_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
        check("crc_after_clear", crc_out, 32'h0000_0000);

        // Table of frames.
        for (int v = 0; v < 8; v++) begin
            send_vec(vecs[v]);
        end

        // in_valid held high through a whole frame.
        gap_bad = 0;
        exp_q.push_back({good.ok, good.ok_care, good.len});
        for (int i = 0; i < 13; i++) begin
            send(vbyte(good, i), (i == 12), 1'b1, w);
            if (i > 0 && w != 8) gap_bad++;
        end
        in_valid = 1'b0;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!chk_valid && k < 20);
        check("report_latency", 32'(k), 32'd9);
        check("held_gap_errors", 32'(gap_bad), 32'd0);
        wait_quiet();

        // clear during the SHIFT of byte 5.
        for (int i = 0; i < 5; i++) begin
            send(vbyte(good, i), 1'b0, 1'b0, w);
        end
        @(negedge CLK);
        @(negedge CLK);
        check("busy_before_clear", 32'(busy), 32'd1);
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
        check("busy_after_clear", 32'(busy), 32'd0);
        send_vec(good);

        // clear and in_valid in the same idle cycle.
        @(negedge CLK);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h55;
        in_last  = 1'b1;
        #1;
        check("ready_during_clear", 32'(in_ready), 32'd0);
        @(negedge CLK);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("byte_not_taken", 32'(busy), 32'd0);
        send_vec(good);

        // Asynchronous reset in the middle of a SHIFT.
        for (int i = 0; i < 3; i++) begin
            send(vbyte(good, i), 1'b0, 1'b0, w);
        end
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_crc_out", crc_out, 32'h0000_0000);
        check("arst_chk_ok", 32'(chk_ok), 32'd0);
        check("arst_frame_len", 32'(frame_len), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        send_vec(good);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
